// File: rtl/sb_rx_msg_queue_pkg.sv
// Sideband RX message queue: opcode/msgcode constants, header field positions,
// FSM state type and the queued header entry.
package sb_rx_pkg;
  localparam logic [4:0]  OP_MSG_NODATA = 5'h12;
  localparam logic [4:0]  OP_MSG_DATA   = 5'h1B;
  localparam logic [7:0]  RDI_REQ       = 8'h01;
  localparam logic [7:0]  RDI_RSP       = 8'h02;

  localparam int OPCODE_LSB  = 0;
  localparam int OPCODE_MSB  = 4;
  localparam int MSGCODE_LSB = 14;
  localparam int MSGCODE_MSB = 21;
  localparam int SUBCODE_LSB = 32;
  localparam int SUBCODE_MSB = 39;
  localparam int MSGINFO_LSB = 40;
  localparam int MSGINFO_MSB = 55;
  localparam int DP_BIT      = 62;
  localparam int CP_BIT      = 63;

  localparam logic [63:0] START_PATTERN = 64'hAAAA_AAAA_AAAA_AAAA;

  typedef enum logic [1:0] {IDLE, WAIT_DATA, PUSH} rx_state_e;

  // Header part of a FIFO entry; the PAYLOAD_W payload is appended below it.
  typedef struct packed {
    logic        is_rdi;
    logic        has_data;
    logic [7:0]  code;
    logic [7:0]  sub_code;
    logic [15:0] info;
  } msg_entry_t;

  // Even parity over the header body, carried in CP.
  function automatic logic hdr_parity_ok(input logic [63:0] w);
    return (^w[CP_BIT-2:0]) == w[CP_BIT];
  endfunction
endpackage

// File: rtl/sb_rx_msg_queue_if.sv
// Deserializer-in / message-out bundle of the sideband RX queue.
interface sb_rx_msg_queue_if #(parameter int DEPTH = 4, parameter int PAYLOAD_W = 16);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                 i_enable;
  logic                 i_de_ser_done;
  logic [63:0]          i_deser_data;
  logic                 i_pop;
  logic                 i_clr_err;
  logic                 o_msg_valid;
  logic                 o_msg_is_rdi;
  logic [7:0]           o_msg_code;
  logic [7:0]           o_msg_sub_code;
  logic [15:0]          o_msg_info;
  logic                 o_msg_has_data;
  logic [PAYLOAD_W-1:0] o_msg_data;
  logic [CNT_W-1:0]     o_count;
  logic                 o_parity_error;
  logic                 o_unsupported;
  logic                 o_overflow;

  modport slave (
    input  i_enable, i_de_ser_done, i_deser_data, i_pop, i_clr_err,
    output o_msg_valid, o_msg_is_rdi, o_msg_code, o_msg_sub_code, o_msg_info,
           o_msg_has_data, o_msg_data, o_count, o_parity_error, o_unsupported, o_overflow
  );
  modport master (
    output i_enable, i_de_ser_done, i_deser_data, i_pop, i_clr_err,
    input  o_msg_valid, o_msg_is_rdi, o_msg_code, o_msg_sub_code, o_msg_info,
           o_msg_has_data, o_msg_data, o_count, o_parity_error, o_unsupported, o_overflow
  );
endinterface

// File: rtl/sb_rx_msg_queue_fifo.sv
// Message FIFO with wrap-bit pointers; a push into a full FIFO is accepted
// only when a pop frees the head slot in the same cycle.
module sb_rx_msg_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic [W-1:0]           i_wdata,
  input  logic                   i_pop,
  output logic [W-1:0]           o_rdata,
  output logic                   o_empty,
  output logic                   o_drop,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr, rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         full, do_push, do_pop;

  assign o_empty = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!full || do_pop);
  assign o_drop  = i_push && full && !do_pop;
  assign o_count = wr_ptr - rd_ptr;
  assign o_rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; the top masks head fields whenever the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= i_wdata;
  end
endmodule

// File: rtl/sb_rx_msg_queue.sv
// Sideband RX: decodes header/data words from the deserializer, checks parity
// and opcode, and queues complete messages for the consumer.
module sb_rx_msg_queue
  import sb_rx_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int PAYLOAD_W = 16
) (
  input logic               i_clk,
  input logic               i_rst_n,
  sb_rx_msg_queue_if.slave  bus
);
  localparam int HW = $bits(msg_entry_t);
  localparam int EW = HW + PAYLOAD_W;

  rx_state_e            state;
  msg_entry_t           hdr_q, head;
  logic [PAYLOAD_W-1:0] data_q;
  logic                 dp_q;
  logic                 parity_error, unsupported, overflow;
  logic [EW-1:0]        rdata;
  logic                 empty, drop;
  logic [63:0]          w;
  logic                 strobe;
  logic [4:0]           op;
  msg_entry_t           hdr_dec;

  assign w      = bus.i_deser_data;
  assign strobe = bus.i_de_ser_done && bus.i_enable;
  assign op     = w[OPCODE_MSB:OPCODE_LSB];

  always_comb begin
    hdr_dec          = '0;
    hdr_dec.code     = w[MSGCODE_MSB:MSGCODE_LSB];
    hdr_dec.sub_code = w[SUBCODE_MSB:SUBCODE_LSB];
    hdr_dec.info     = w[MSGINFO_MSB:MSGINFO_LSB];
    hdr_dec.is_rdi   = (hdr_dec.code == RDI_REQ) || (hdr_dec.code == RDI_RSP);
    hdr_dec.has_data = (op == OP_MSG_DATA);
  end

  // PUSH decodes a new header exactly like IDLE, so back-to-back strobes are kept;
  // the entry being written this edge is the old hdr_q/data_q value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      hdr_q        <= '0;
      data_q       <= '0;
      dp_q         <= 1'b0;
      parity_error <= 1'b0;
      unsupported  <= 1'b0;
    end else begin
      parity_error <= 1'b0;
      unsupported  <= 1'b0;
      unique case (state)
        IDLE, PUSH: begin
          state <= IDLE;
          if (strobe && w != START_PATTERN) begin
            if (!hdr_parity_ok(w)) begin
              parity_error <= 1'b1;
            end else if (op == OP_MSG_NODATA) begin
              hdr_q  <= hdr_dec;
              data_q <= '0;
              state  <= PUSH;
            end else if (op == OP_MSG_DATA) begin
              hdr_q <= hdr_dec;
              dp_q  <= w[DP_BIT];
              state <= WAIT_DATA;
            end else begin
              unsupported <= 1'b1;
            end
          end
        end
        WAIT_DATA: begin
          if (!bus.i_enable) begin
            state <= IDLE;
          end else if (bus.i_de_ser_done) begin
            if ((^w) == dp_q) begin
              data_q <= w[PAYLOAD_W-1:0];
              state  <= PUSH;
            end else begin
              parity_error <= 1'b1;
              state        <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky overflow; a new drop beats a simultaneous clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)           overflow <= 1'b0;
    else if (drop)          overflow <= 1'b1;
    else if (bus.i_clr_err) overflow <= 1'b0;
  end

  sb_rx_msg_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (state == PUSH),
    .i_wdata ({hdr_q, data_q}),
    .i_pop   (bus.i_pop),
    .o_rdata (rdata),
    .o_empty (empty),
    .o_drop  (drop),
    .o_count (bus.o_count)
  );

  assign head               = empty ? '0 : msg_entry_t'(rdata[EW-1:PAYLOAD_W]);
  assign bus.o_msg_valid    = !empty;
  assign bus.o_msg_is_rdi   = head.is_rdi;
  assign bus.o_msg_has_data = head.has_data;
  assign bus.o_msg_code     = head.code;
  assign bus.o_msg_sub_code = head.sub_code;
  assign bus.o_msg_info     = head.info;
  assign bus.o_msg_data     = empty ? '0 : rdata[PAYLOAD_W-1:0];
  assign bus.o_parity_error = parity_error;
  assign bus.o_unsupported  = unsupported;
  assign bus.o_overflow     = overflow;
endmodule

// File: tb/tb_sb_rx_msg_queue.sv
// Directed bench for sb_rx_msg_queue: single-message vector table plus
// hand sequences for overflow, enable drop and mid-message reset.
module tb_sb_rx_msg_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sb_rx_msg_queue_if #(.DEPTH(4), .PAYLOAD_W(16)) bus ();
  sb_rx_msg_queue #(.DEPTH(4), .PAYLOAD_W(16)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [4:0]  op;
    logic [7:0]  code, sub;
    logic [15:0] info;
    logic [63:0] data;
    logic        bad_cp, bad_dp, start;
    logic        e_perr, e_unsup, e_valid, e_rdi, e_hd;
    logic [15:0] e_data;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [63:0] mk_hdr(input logic [4:0] op, input logic [7:0] code,
                                         input logic [7:0] sub, input logic [15:0] info,
                                         input logic dp, input logic bad_cp);
    logic [63:0] h;
    h = '0;
    h[4:0]   = op;
    h[21:14] = code;
    h[39:32] = sub;
    h[55:40] = info;
    h[62]    = dp;
    h[63]    = (^h[61:0]) ^ bad_cp;
    return h;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [63:0] w);
    bus.i_de_ser_done = 1'b1;
    bus.i_deser_data  = w;
    tick();
    bus.i_de_ser_done = 1'b0;
  endtask

  task automatic send_nodata(input logic [7:0] code);
    send_word(mk_hdr(5'h12, code, 8'h00, 16'h0000, 1'b0, 1'b0));
  endtask

  task automatic pop1();
    bus.i_pop = 1'b1;
    tick();
    bus.i_pop = 1'b0;
  endtask

  initial begin
    logic [63:0] h;
    logic [7:0]  drain[4];

    vecs[0] = '{5'h12, 8'h85, 8'h00, 16'h0003, 64'h0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0000};
    vecs[1] = '{5'h1B, 8'h01, 8'h00, 16'h0000, 64'hBEEF, 0, 0, 0, 0, 0, 1, 1, 1, 16'hBEEF};
    vecs[2] = '{5'h1B, 8'h02, 8'h5A, 16'h1234, 64'h1234_5678_9ABC_DEF0, 0, 0, 0, 0, 0, 1, 1, 1, 16'hDEF0};
    vecs[3] = '{5'h12, 8'h03, 8'hFF, 16'hFFFF, 64'h0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0000};
    vecs[4] = '{5'h12, 8'h85, 8'h00, 16'h0003, 64'h0, 1, 0, 0, 1, 0, 0, 0, 0, 16'h0000};
    vecs[5] = '{5'h12, 8'h40, 8'h01, 16'h0002, 64'h0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0000};
    vecs[6] = '{5'h05, 8'h00, 8'h00, 16'h0000, 64'h0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0000};
    vecs[7] = '{5'h1B, 8'h01, 8'h00, 16'h0000, 64'hBEEF, 0, 1, 0, 1, 0, 0, 0, 0, 16'h0000};
    vecs[8] = '{5'h00, 8'h00, 8'h00, 16'h0000, 64'h0, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0000};
    vecs[9] = '{5'h1B, 8'h7F, 8'h11, 16'h2222, 64'h0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0000};

    bus.i_enable = 1'b1; bus.i_de_ser_done = 1'b0; bus.i_deser_data = '0;
    bus.i_pop = 1'b0; bus.i_clr_err = 1'b0;
    tick(); tick();
    chk("reset_valid", bus.o_msg_valid, 0);
    chk("reset_count", bus.o_count, 0);
    chk("reset_code", bus.o_msg_code, 0);
    chk("reset_ovf", bus.o_overflow, 0);
    rst_n = 1'b1;
    tick();

    // Single-message vectors
    for (int i = 0; i < 10; i++) begin
      h = vecs[i].start ? 64'hAAAA_AAAA_AAAA_AAAA
                        : mk_hdr(vecs[i].op, vecs[i].code, vecs[i].sub, vecs[i].info,
                                 (^vecs[i].data) ^ vecs[i].bad_dp, vecs[i].bad_cp);
      send_word(h);
      if (vecs[i].op == 5'h1B && !vecs[i].start) send_word(vecs[i].data);
      chk($sformatf("v%0d_perr", i), bus.o_parity_error, vecs[i].e_perr);
      chk($sformatf("v%0d_unsup", i), bus.o_unsupported, vecs[i].e_unsup);
      tick();
      chk($sformatf("v%0d_valid", i), bus.o_msg_valid, vecs[i].e_valid);
      chk($sformatf("v%0d_count", i), bus.o_count, vecs[i].e_valid ? 1 : 0);
      chk($sformatf("v%0d_perr_end", i), bus.o_parity_error, 0);
      chk($sformatf("v%0d_unsup_end", i), bus.o_unsupported, 0);
      chk($sformatf("v%0d_rdi", i), bus.o_msg_is_rdi, vecs[i].e_rdi);
      chk($sformatf("v%0d_hd", i), bus.o_msg_has_data, vecs[i].e_hd);
      chk($sformatf("v%0d_code", i), bus.o_msg_code, vecs[i].e_valid ? vecs[i].code : 8'h00);
      chk($sformatf("v%0d_sub", i), bus.o_msg_sub_code, vecs[i].e_valid ? vecs[i].sub : 8'h00);
      chk($sformatf("v%0d_info", i), bus.o_msg_info, vecs[i].e_valid ? vecs[i].info : 16'h0000);
      chk($sformatf("v%0d_data", i), bus.o_msg_data, vecs[i].e_data);
      if (vecs[i].e_valid) begin
        pop1();
        chk($sformatf("v%0d_popped", i), bus.o_count, 0);
      end
    end

    // Partial message dropped by enable low; the data word then decodes as a header
    send_word(mk_hdr(5'h1B, 8'h01, 8'h00, 16'h0000, ^64'hBEEF, 1'b0));
    bus.i_enable = 1'b0;
    tick();
    bus.i_enable = 1'b1;
    send_word(64'hBEEF);
    tick(); tick();
    chk("en_drop_count", bus.o_count, 0);
    chk("en_drop_valid", bus.o_msg_valid, 0);
    send_nodata(8'h33);
    tick();
    chk("en_after_valid", bus.o_msg_valid, 1);
    chk("en_after_code", bus.o_msg_code, 8'h33);
    pop1();

    // Five back-to-back messages into DEPTH=4
    for (int i = 0; i < 5; i++) send_nodata(8'h10 + 8'(i));
    tick();
    chk("full_count", bus.o_count, 4);
    chk("full_ovf", bus.o_overflow, 1);
    chk("full_head", bus.o_msg_code, 8'h10);
    bus.i_clr_err = 1'b1;
    tick();
    bus.i_clr_err = 1'b0;
    chk("clr_ovf", bus.o_overflow, 0);
    send_nodata(8'h20);
    bus.i_pop = 1'b1;
    tick();
    bus.i_pop = 1'b0;
    chk("pushpop_count", bus.o_count, 4);
    chk("pushpop_ovf", bus.o_overflow, 0);
    chk("pushpop_head", bus.o_msg_code, 8'h11);
    send_nodata(8'h21);
    bus.i_clr_err = 1'b1;
    tick();
    bus.i_clr_err = 1'b0;
    chk("setwins_ovf", bus.o_overflow, 1);
    chk("setwins_count", bus.o_count, 4);
    drain = '{8'h11, 8'h12, 8'h13, 8'h20};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d", i), bus.o_msg_code, drain[i]);
      pop1();
    end
    chk("drain_count", bus.o_count, 0);
    pop1();
    chk("pop_empty_count", bus.o_count, 0);
    chk("pop_empty_valid", bus.o_msg_valid, 0);

    // Reset with three queued messages and a data message in flight
    for (int i = 0; i < 3; i++) send_nodata(8'h50 + 8'(i));
    tick();
    chk("pre_rst_count", bus.o_count, 3);
    send_word(mk_hdr(5'h1B, 8'h02, 8'h00, 16'h0000, 1'b0, 1'b0));
    rst_n = 1'b0;
    #1;
    chk("rst_valid", bus.o_msg_valid, 0);
    chk("rst_count", bus.o_count, 0);
    chk("rst_ovf", bus.o_overflow, 0);
    chk("rst_code", bus.o_msg_code, 0);
    chk("rst_rdi", bus.o_msg_is_rdi, 0);
    chk("rst_hd", bus.o_msg_has_data, 0);
    chk("rst_info", bus.o_msg_info, 0);
    chk("rst_data", bus.o_msg_data, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_exit_perr", bus.o_parity_error, 0);
    chk("rst_exit_unsup", bus.o_unsupported, 0);
    send_nodata(8'h77);
    chk("post_rst_lat1", bus.o_msg_valid, 0);
    tick();
    chk("post_rst_lat2", bus.o_msg_valid, 1);
    chk("post_rst_code", bus.o_msg_code, 8'h77);
    chk("post_rst_count", bus.o_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
